playback_sequencer: RTL and testbench
=====================================

Name: playback_sequencer

Overview:
- Transport controller for the MP3 player: owns current track index, play/pause/stop state and the decoder load handshake.
- Sequences the elapsed-time counter through a one-cycle clear pulse and a 1 Hz tick enable.
- Sits between the debounced button/decoder-status pulses and the decoder + time-display datapath.

Parameters:
NUM_TRACKS, 4, number of tracks; index wraps modulo NUM_TRACKS
TRK_W, 2, track index width, equals clog2(NUM_TRACKS), minimum 1
CLK_HZ, 100000000, clk cycles per timer_tick
PREV_RESTART_S, 3, below this elapsed time, pre selects the previous track; otherwise it restarts the current track
AUTO_ADVANCE, 1, 1: i_finish_song loads the next track; 0: i_finish_song stops

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active low
play_pause  in  1  single-cycle pulse, toggles play/pause
next  in  1  single-cycle pulse, next track
pre  in  1  single-cycle pulse, previous track or restart
i_finish_song  in  1  single-cycle pulse from decoder at end of track
minute  in  8  elapsed minutes from time counter
second  in  8  elapsed seconds from time counter, 0..59
load_ack  in  1  decoder accepted load_req for track_idx
track_idx  out  TRK_W  current track
load_req  out  1  request decoder to load track_idx
playing  out  1  high only in PLAY
timer_clr  out  1  one-cycle pulse, clears time counter
timer_tick  out  1  one-cycle pulse per elapsed second of playback

Behaviour:
- Reset (async, rst_n=0): state STOP, track_idx=0, load_req=0, playing=0, timer_clr=0, timer_tick=0, prescaler=0.
- All outputs are registered. An input sampled at edge N affects outputs after edge N.
- Priority when inputs coincide: next > pre > i_finish_song > play_pause. Only the winner acts.
- Pre rule: if minute==0 and second<PREV_RESTART_S, then idx-1 (0 wraps to NUM_TRACKS-1); otherwise idx unchanged (restart).
- Next rule: idx+1, with NUM_TRACKS-1 wrapping to 0.
- STOP:
  - play_pause -> LOAD.
  - next/pre -> update idx, pulse timer_clr, stay in STOP. Pre uses the same rule; time is normally 0 here, so it moves back.
  - i_finish_song ignored.
- LOAD:
  - On entry: pulse timer_clr for 1 cycle, clear prescaler.
  - load_req=1 held until the cycle load_ack is sampled high. load_req drops at that edge, then -> PLAY.
  - track_idx is stable throughout LOAD.
  - next, pre, play_pause and i_finish_song are ignored (dropped, not queued).
- PLAY:
  - playing=1. Prescaler counts 0..CLK_HZ-1; at wrap, timer_tick=1 for one cycle.
  - play_pause -> PAUSE; prescaler holds its value so resume keeps sub-second phase.
  - next/pre -> update idx, -> LOAD. A restart (pre with idx unchanged) also goes through LOAD.
  - i_finish_song: AUTO_ADVANCE=1 -> idx+1 wrap, -> LOAD. AUTO_ADVANCE=0 -> STOP with idx unchanged, timer_clr pulse.
- PAUSE:
  - playing=0, no ticks.
  - play_pause -> PLAY with no reload.
  - next/pre -> update idx, -> LOAD.
  - i_finish_song ignored.
- Reset mid-LOAD drops load_req immediately (async). The decoder must tolerate an abandoned request.
- load_ack while not in LOAD is ignored.
- The only legal state change without an input event is LOAD->PLAY on load_ack.

Decomposition:
- Shared package: state enum (STOP, LOAD, PLAY, PAUSE; 2-bit encoding) and the TRK_W derivation function (clog2).
- One sub-module, tick_prescaler:
  - Parameter CLK_HZ.
  - Ports clk, rst_n, en, clr, tick.
  - Counter width is clog2(CLK_HZ).
  - Held when en=0, zeroed on clr, tick on terminal count.

Test Plan:
- Reset then play_pause, load_ack 3 cycles later (CLK_HZ=10) -> load_req high for 3 cycles, timer_clr one pulse, playing=1, timer_tick every 10 cycles.
- In PLAY at idx=3, NUM_TRACKS=4, pulse next -> track_idx=0, timer_clr pulse, load_req=1. After ack, playing resumes.
- In PLAY with minute=0, second=2: pre -> idx-1. With minute=0, second=5: pre -> idx unchanged, timer_clr, LOAD.
- next and i_finish_song in the same cycle at idx=1 -> idx=2 (not 3), single LOAD.
- Pause after 4 prescaler cycles, wait 50, resume -> first tick after 6 more cycles. No ticks during pause.
- Assert rst_n low while load_req=1 -> all outputs 0 without waiting for a clock edge, state STOP, track_idx=0. AUTO_ADVANCE=0 finish in PLAY -> STOP, timer_clr pulse, idx unchanged.

Source files
------------

// File: rtl/playback_sequencer_pkg.sv
// rtl/playback_sequencer_pkg.sv - shared transport state encoding and width helper
package playback_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_PLAY  = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    // ceil(log2(n)), never below 1 so single-entry counters still get a bit
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/playback_sequencer_if.sv
// rtl/playback_sequencer_if.sv - button/decoder/time-counter bundle around the sequencer
interface playback_sequencer_if #(
    parameter int TRK_W = 2
);
    logic             play_pause;
    logic             next;
    logic             pre;
    logic             i_finish_song;
    logic [7:0]       minute;
    logic [7:0]       second;
    logic             load_ack;
    logic [TRK_W-1:0] track_idx;
    logic             load_req;
    logic             playing;
    logic             timer_clr;
    logic             timer_tick;

    modport master (
        input  play_pause, next, pre, i_finish_song, minute, second, load_ack,
        output track_idx, load_req, playing, timer_clr, timer_tick
    );

    modport slave (
        output play_pause, next, pre, i_finish_song, minute, second, load_ack,
        input  track_idx, load_req, playing, timer_clr, timer_tick
    );
endinterface

// File: rtl/playback_sequencer_tick_prescaler.sv
// rtl/playback_sequencer_tick_prescaler.sv - clk divider producing one tick per CLK_HZ enabled cycles
module tick_prescaler
    import playback_sequencer_pkg::*;
#(
    parameter int CLK_HZ = 100000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            W    = clog2_min1(CLK_HZ);
    localparam logic [W-1:0]  TERM = W'(CLK_HZ - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (clr) begin
                cnt <= '0;
            end else if (en) begin
                if (cnt == TERM) begin
                    cnt  <= '0;
                    tick <= 1'b1;
                end else begin
                    cnt <= cnt + W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/playback_sequencer.sv
// rtl/playback_sequencer.sv - track index, play/pause/stop FSM and decoder load handshake
module playback_sequencer
    import playback_sequencer_pkg::*;
#(
    parameter int NUM_TRACKS     = 4,
    parameter int TRK_W          = clog2_min1(NUM_TRACKS),
    parameter int CLK_HZ         = 100000000,
    parameter int PREV_RESTART_S = 3,
    parameter int AUTO_ADVANCE   = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    playback_sequencer_if.master bus
);

    localparam logic [TRK_W-1:0] LAST_IDX  = TRK_W'(NUM_TRACKS - 1);
    localparam logic [7:0]       RESTART_S = 8'(PREV_RESTART_S);

    state_t           state;
    logic [TRK_W-1:0] track_idx;
    logic [TRK_W-1:0] idx_next;
    logic [TRK_W-1:0] idx_pre;
    logic             load_req;
    logic             playing;
    logic             timer_clr;
    logic             tick;
    logic             near_start;
    logic             any_event;
    logic             pre_en;
    logic             pre_clr;

    always_comb begin
        idx_next   = (track_idx == LAST_IDX) ? '0 : track_idx + TRK_W'(1);
        near_start = (bus.minute == 8'd0) && (bus.second < RESTART_S);
        if (!near_start)
            idx_pre = track_idx;
        else if (track_idx == '0)
            idx_pre = LAST_IDX;
        else
            idx_pre = track_idx - TRK_W'(1);
        any_event = bus.next | bus.pre | bus.i_finish_song | bus.play_pause;
    end

    // Gate counting on the edge that leaves PLAY so no tick lands in PAUSE/LOAD
    assign pre_en  = (state == ST_PLAY) && !any_event;
    assign pre_clr = (state == ST_LOAD) || (state == ST_STOP);

    tick_prescaler #(
        .CLK_HZ(CLK_HZ)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (pre_en),
        .clr  (pre_clr),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_STOP;
            track_idx <= '0;
            load_req  <= 1'b0;
            playing   <= 1'b0;
            timer_clr <= 1'b0;
        end else begin
            timer_clr <= 1'b0;
            case (state)
                ST_STOP: begin
                    if (bus.next) begin
                        track_idx <= idx_next;
                        timer_clr <= 1'b1;
                    end else if (bus.pre) begin
                        track_idx <= idx_pre;
                        timer_clr <= 1'b1;
                    end else if (bus.play_pause) begin
                        state     <= ST_LOAD;
                        load_req  <= 1'b1;
                        timer_clr <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (bus.load_ack) begin
                        state    <= ST_PLAY;
                        load_req <= 1'b0;
                        playing  <= 1'b1;
                    end
                end
                ST_PLAY, ST_PAUSE: begin
                    if (bus.next || bus.pre ||
                        (state == ST_PLAY && bus.i_finish_song && AUTO_ADVANCE != 0)) begin
                        track_idx <= bus.next ? idx_next : (bus.pre ? idx_pre : idx_next);
                        state     <= ST_LOAD;
                        load_req  <= 1'b1;
                        timer_clr <= 1'b1;
                        playing   <= 1'b0;
                    end else if (state == ST_PLAY && bus.i_finish_song) begin
                        state     <= ST_STOP;
                        timer_clr <= 1'b1;
                        playing   <= 1'b0;
                    end else if (bus.play_pause) begin
                        state   <= (state == ST_PLAY) ? ST_PAUSE : ST_PLAY;
                        playing <= (state == ST_PAUSE);
                    end
                end
                default: state <= ST_STOP;
            endcase
        end
    end

    assign bus.track_idx  = track_idx;
    assign bus.load_req   = load_req;
    assign bus.playing    = playing;
    assign bus.timer_clr  = timer_clr;
    assign bus.timer_tick = tick;

endmodule

// File: tb/tb_playback_sequencer.sv
// tb/tb_playback_sequencer.sv - directed scoreboard bench for playback_sequencer
module tb_playback_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];

    playback_sequencer_if #(.TRK_W(2)) a_if();
    playback_sequencer_if #(.TRK_W(2)) b_if();

    playback_sequencer #(
        .NUM_TRACKS(4), .TRK_W(2), .CLK_HZ(10), .PREV_RESTART_S(3), .AUTO_ADVANCE(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(a_if)
    );

    playback_sequencer #(
        .NUM_TRACKS(4), .TRK_W(2), .CLK_HZ(10), .PREV_RESTART_S(3), .AUTO_ADVANCE(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(b_if)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // 0 next, 1 pre, 2 finish, 3 play_pause
    task automatic press(input int which);
        case (which)
            0:       a_if.next = 1'b1;
            1:       a_if.pre = 1'b1;
            2:       a_if.i_finish_song = 1'b1;
            default: a_if.play_pause = 1'b1;
        endcase
        step();
        a_if.next = 1'b0;
        a_if.pre = 1'b0;
        a_if.i_finish_song = 1'b0;
        a_if.play_pause = 1'b0;
    endtask

    task automatic load_and_play(input string tag, input logic [1:0] exp_idx);
        chk({tag, "_idx"}, 32'(a_if.track_idx), 32'(exp_idx));
        chk({tag, "_req"}, 32'(a_if.load_req), 1);
        chk({tag, "_clr"}, 32'(a_if.timer_clr), 1);
        a_if.load_ack = 1'b1;
        step();
        a_if.load_ack = 1'b0;
        chk({tag, "_playing"}, 32'(a_if.playing), 1);
        chk({tag, "_req_drop"}, 32'(a_if.load_req), 0);
    endtask

    task automatic wait_tick(input string tag, input int exp_n);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (a_if.timer_tick !== 1'b1 && n < 40);
        chk(tag, n, exp_n);
    endtask

    // Scoreboard: every rising load_req of dut_a must present the next expected track
    initial begin
        logic       prev;
        logic [1:0] e;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (a_if.load_req === 1'b1 && prev !== 1'b1) begin
                chk("sb_pending", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("sb_load_idx", 32'(a_if.track_idx), 32'(e));
                end
            end
            prev = a_if.load_req;
        end
    end

    initial begin
        int ticks;
        {a_if.play_pause, a_if.next, a_if.pre, a_if.i_finish_song, a_if.load_ack} = '0;
        {b_if.play_pause, b_if.next, b_if.pre, b_if.i_finish_song, b_if.load_ack} = '0;
        a_if.minute = 8'd0; a_if.second = 8'd0;
        b_if.minute = 8'd0; b_if.second = 8'd0;

        step();
        step();
        chk("rst_idx", 32'(a_if.track_idx), 0);
        chk("rst_req", 32'(a_if.load_req), 0);
        chk("rst_playing", 32'(a_if.playing), 0);
        chk("rst_clr", 32'(a_if.timer_clr), 0);
        chk("rst_tick", 32'(a_if.timer_tick), 0);
        rst_n = 1'b1;
        step();

        // First play: load_req for exactly three cycles, ack sampled on the third edge
        exp_q.push_back(2'd0);
        press(3);
        chk("ld0_req", 32'(a_if.load_req), 1);
        chk("ld0_clr", 32'(a_if.timer_clr), 1);
        chk("ld0_playing", 32'(a_if.playing), 0);
        step();
        chk("ld1_req", 32'(a_if.load_req), 1);
        chk("ld1_clr", 32'(a_if.timer_clr), 0);
        step();
        chk("ld2_req", 32'(a_if.load_req), 1);
        a_if.load_ack = 1'b1;
        step();
        a_if.load_ack = 1'b0;
        chk("ld3_req", 32'(a_if.load_req), 0);
        chk("ld3_playing", 32'(a_if.playing), 1);
        wait_tick("tick_first", 10);
        wait_tick("tick_period", 10);

        // Pause with prescaler at 4, idle 50, resume: tick six cycles later
        repeat (4) step();
        press(3);
        chk("pause_playing", 32'(a_if.playing), 0);
        ticks = 0;
        repeat (50) begin
            step();
            if (a_if.timer_tick === 1'b1) ticks++;
        end
        chk("pause_no_tick", ticks, 0);
        press(3);
        chk("resume_playing", 32'(a_if.playing), 1);
        chk("resume_no_reload", 32'(a_if.load_req), 0);
        wait_tick("resume_tick", 6);

        a_if.load_ack = 1'b1;
        step();
        a_if.load_ack = 1'b0;
        chk("stray_ack_playing", 32'(a_if.playing), 1);
        chk("stray_ack_req", 32'(a_if.load_req), 0);

        exp_q.push_back(2'd1); press(0); load_and_play("next1", 2'd1);
        exp_q.push_back(2'd2); press(0); load_and_play("next2", 2'd2);
        exp_q.push_back(2'd3); press(0); load_and_play("next3", 2'd3);
        exp_q.push_back(2'd0); press(0); load_and_play("next_wrap", 2'd0);

        a_if.second = 8'd2;
        exp_q.push_back(2'd3); press(1); load_and_play("pre_wrap", 2'd3);
        a_if.second = 8'd3;
        exp_q.push_back(2'd3); press(1); load_and_play("pre_restart_s3", 2'd3);
        a_if.second = 8'd5;
        exp_q.push_back(2'd3); press(1); load_and_play("pre_restart_s5", 2'd3);
        a_if.minute = 8'd1; a_if.second = 8'd0;
        exp_q.push_back(2'd3); press(1); load_and_play("pre_restart_m1", 2'd3);
        a_if.minute = 8'd0; a_if.second = 8'd2;
        exp_q.push_back(2'd2); press(1); load_and_play("pre_back", 2'd2);
        a_if.second = 8'd0;
        exp_q.push_back(2'd1); press(1); load_and_play("pre_back2", 2'd1);

        // next and finish together at idx 1: next wins alone; LOAD then ignores events
        exp_q.push_back(2'd2);
        a_if.next = 1'b1;
        a_if.i_finish_song = 1'b1;
        step();
        a_if.next = 1'b0;
        a_if.i_finish_song = 1'b0;
        chk("coinc_idx", 32'(a_if.track_idx), 2);
        chk("coinc_req", 32'(a_if.load_req), 1);
        a_if.pre = 1'b1;
        a_if.play_pause = 1'b1;
        a_if.i_finish_song = 1'b1;
        step();
        {a_if.pre, a_if.play_pause, a_if.i_finish_song} = '0;
        press(0);
        chk("load_ign_idx", 32'(a_if.track_idx), 2);
        chk("load_ign_req", 32'(a_if.load_req), 1);
        chk("load_ign_clr", 32'(a_if.timer_clr), 0);
        chk("load_ign_playing", 32'(a_if.playing), 0);
        a_if.load_ack = 1'b1;
        step();
        a_if.load_ack = 1'b0;
        chk("coinc_playing", 32'(a_if.playing), 1);

        exp_q.push_back(2'd3); press(2); load_and_play("finish_adv", 2'd3);
        press(3);
        chk("pause2_playing", 32'(a_if.playing), 0);
        exp_q.push_back(2'd0); press(0); load_and_play("pause_next", 2'd0);

        // Asynchronous reset in the middle of a load
        exp_q.push_back(2'd1);
        press(0);
        chk("pre_rst_req", 32'(a_if.load_req), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(a_if.load_req), 0);
        chk("arst_idx", 32'(a_if.track_idx), 0);
        chk("arst_playing", 32'(a_if.playing), 0);
        chk("arst_clr", 32'(a_if.timer_clr), 0);
        chk("arst_tick", 32'(a_if.timer_tick), 0);
        step();
        rst_n = 1'b1;
        step();

        press(0);
        chk("stop_next_idx", 32'(a_if.track_idx), 1);
        chk("stop_next_clr", 32'(a_if.timer_clr), 1);
        chk("stop_next_req", 32'(a_if.load_req), 0);
        chk("stop_next_playing", 32'(a_if.playing), 0);
        press(2);
        chk("stop_finish_idx", 32'(a_if.track_idx), 1);
        chk("stop_finish_clr", 32'(a_if.timer_clr), 0);
        press(1);
        chk("stop_pre_idx", 32'(a_if.track_idx), 0);

        // AUTO_ADVANCE=0 instance: finish stops on the same track
        b_if.play_pause = 1'b1; step(); b_if.play_pause = 1'b0;
        b_if.load_ack = 1'b1; step(); b_if.load_ack = 1'b0;
        chk("b_playing", 32'(b_if.playing), 1);
        b_if.next = 1'b1; step(); b_if.next = 1'b0;
        b_if.load_ack = 1'b1; step(); b_if.load_ack = 1'b0;
        b_if.i_finish_song = 1'b1; step(); b_if.i_finish_song = 1'b0;
        chk("b_stop_playing", 32'(b_if.playing), 0);
        chk("b_stop_clr", 32'(b_if.timer_clr), 1);
        chk("b_stop_idx", 32'(b_if.track_idx), 1);
        chk("b_stop_req", 32'(b_if.load_req), 0);
        step();
        chk("b_clr_one_cycle", 32'(b_if.timer_clr), 0);

        step();
        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
